// File: rtl/spi_sram_responder.sv
// SPI mode-0 target emulating a serial SRAM (READ 0x03 / WRITE 0x02, sequential mode).
// All SPI pins are oversampled in the clk domain; contents live in an internal byte array.
module spi_sram_responder #(
    parameter int MEM_AW      = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              sck,
    input  logic              css,
    input  logic              sdi,
    output logic              sdo,
    output logic              sdo_en,
    output logic              busy,
    output logic              bad_cmd,
    input  logic [MEM_AW-1:0] dbg_addr,
    output logic [7:0]        dbg_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WR,
        S_RD,
        S_IGNORE
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] css_sync_q;
    logic [SYNC_STAGES-1:0] sdi_sync_q;
    logic                   sck_prev_q;
    logic                   css_prev_q;

    state_t                 state_q;
    logic [4:0]             cnt_q;
    logic [6:0]             sh_q;
    logic [MEM_AW-1:0]      addr_q;
    logic [7:0]             tx_q;
    logic                   rd_q;
    logic                   pf_q;
    logic                   sdo_q;
    logic                   sdo_en_q;
    logic                   busy_q;
    logic                   bad_cmd_q;

    logic [7:0]             mem [2**MEM_AW];

    logic                   sck_s;
    logic                   css_s;
    logic                   sdi_s;
    logic                   sck_rise;
    logic                   sck_fall;
    logic                   css_rise;
    logic                   css_fall;
    logic [7:0]             rx_byte;
    logic [7:0]             rd_byte;
    logic [MEM_AW-1:0]      addr_inc;
    logic                   wr_en;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign css_s    = css_sync_q[SYNC_STAGES-1];
    assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign css_rise = css_s & ~css_prev_q;
    assign css_fall = ~css_s & css_prev_q;

    assign rx_byte  = {sh_q, sdi_s};
    assign rd_byte  = mem[addr_q];
    assign addr_inc = addr_q + MEM_AW'(1);
    assign wr_en    = (state_q == S_WR) && sck_rise && (cnt_q == 5'd7) && !css_rise;

    assign sdo      = sdo_q;
    assign sdo_en   = sdo_en_q;
    assign busy     = busy_q;
    assign bad_cmd  = bad_cmd_q;
    assign dbg_data = mem[dbg_addr];

    // css resets to "low" so a frame already in progress at reset release
    // produces no fall; a genuine css high-then-low is needed to start.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            sck_sync_q <= '0;
            css_sync_q <= '0;
            sdi_sync_q <= '0;
            sck_prev_q <= 1'b0;
            css_prev_q <= 1'b0;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            css_sync_q <= {css_sync_q[SYNC_STAGES-2:0], css};
            sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            sck_prev_q <= sck_s;
            css_prev_q <= css_s;
        end
    end

    // NOTE: the byte array has no reset; it models SRAM contents and clearing it would block RAM inference.
    always_ff @(posedge clk) begin
        if (wr_en) mem[addr_q] <= rx_byte;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            sh_q      <= '0;
            addr_q    <= '0;
            tx_q      <= '0;
            rd_q      <= 1'b0;
            pf_q      <= 1'b0;
            sdo_q     <= 1'b0;
            sdo_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            bad_cmd_q <= 1'b0;
        end else begin
            bad_cmd_q <= 1'b0;
            pf_q      <= 1'b0;
            if (state_q != S_IDLE && css_rise) begin
                state_q  <= S_IDLE;
                busy_q   <= 1'b0;
                sdo_en_q <= 1'b0;
                sdo_q    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (css_fall) begin
                            state_q <= S_CMD;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    S_CMD: begin
                        if (sck_rise) begin
                            sh_q <= {sh_q[5:0], sdi_s};
                            if (cnt_q == 5'd7) begin
                                cnt_q <= '0;
                                if (rx_byte == 8'h02) begin
                                    state_q <= S_ADDR;
                                    rd_q    <= 1'b0;
                                end else if (rx_byte == 8'h03) begin
                                    state_q <= S_ADDR;
                                    rd_q    <= 1'b1;
                                end else begin
                                    state_q   <= S_IGNORE;
                                    bad_cmd_q <= 1'b1;
                                end
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                    end
                    S_ADDR: begin
                        // Shifting through a MEM_AW-wide register drops the upper address bits.
                        if (sck_rise) begin
                            addr_q <= {addr_q[MEM_AW-2:0], sdi_s};
                            if (cnt_q == 5'd23) begin
                                cnt_q   <= '0;
                                state_q <= rd_q ? S_RD : S_WR;
                                pf_q    <= rd_q;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                    end
                    S_WR: begin
                        if (sck_rise) begin
                            sh_q <= {sh_q[5:0], sdi_s};
                            if (cnt_q == 5'd7) begin
                                cnt_q  <= '0;
                                addr_q <= addr_inc;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                            end
                        end
                    end
                    S_RD: begin
                        // Falls count bits out; the 8th fall still presents bit 0 while the next byte loads.
                        if (pf_q) begin
                            tx_q   <= rd_byte;
                            addr_q <= addr_inc;
                        end else if (sck_fall) begin
                            sdo_en_q <= 1'b1;
                            sdo_q    <= tx_q[7];
                            if (cnt_q == 5'd7) begin
                                cnt_q  <= '0;
                                tx_q   <= rd_byte;
                                addr_q <= addr_inc;
                            end else begin
                                cnt_q <= cnt_q + 5'd1;
                                tx_q  <= {tx_q[6:0], 1'b0};
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
